data_path: RTL and testbench
============================

Name: data_path

Overview:
- 32-bit single-bus CPU datapath: register file R0–R15, PC, IR, MAR, MDR, Y, HI, LO, and a 64-bit Z (ZHigh/ZLow).
- All transfers go over one shared 32-bit bus, chosen by a prioritized bus encoder from one-hot "out" strobes.
- The ALU takes operand A from Y and operand B from the bus; the result is captured in Z.
- An external control-unit FSM or testbench drives every strobe. This block contains no sequencer.

Parameters:
- WIDTH, 32, bus and register width (Z is 2*WIDTH).

Ports:
- clock  in  1  rising-edge system clock
- clear  in  1  reset, asynchronous, active-high; clears every register
- PCout, Zhighout, Zlowout, MDRout  in  1 each  bus-drive strobes
- R0out, R2out, R3out, R4out, R5out, R6out, R7out  in  1 each  register bus-drive strobes
- Cin  in  1  drive sign-extended IR[18:0] onto the bus
- MARin, PCin, MDRin, IRin, Yin  in  1 each  load enables from the bus
- IncPC  in  1  increment PC
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- opcode  in  5  ALU operation select
- R0in … R15in  in  1 each  register load enables
- HIin, LOin  in  1 each  HI/LO load enables from the bus
- ZHighIn, ZLowIn  in  1 each  load Z[63:32] / Z[31:0] from the ALU result
- Mdatain  in  32  memory read data

Behaviour:
- Reset: on clear=1, all registers go to 0 immediately, independent of clock.
- Register update: every register updates on the rising edge of clock when its enable is high. No other register changes.
- Bus is combinational.
  - Driver priority, highest first: MDRout, PCout, Zhighout, Zlowout, Cin, R0out, R2out, R3out, R4out, R5out, R6out, R7out.
  - With no strobe asserted, the bus is 0.
  - Several strobes asserted at once: the highest-priority one wins. This is legal, never an error.
- MDR: when MDRin=1, MDR ← (Read ? Mdatain : bus).
- PC:
  - PCin=1 → PC ← bus.
  - Otherwise IncPC=1 → PC ← PC+1.
  - PCin has priority over IncPC.
- MAR, IR, Y, HI, LO, R0–R15: each loads the bus value when its enable is high. R0 is an ordinary register.
- ALU: combinational, 64-bit result; A = Y, B = bus.
  - 00011 add
  - 00100 sub (A−B)
  - 00101 and
  - 00110 or
  - 00111 ror
  - 01000 rol
  - 01001 shr (logical right)
  - 01010 shra (arithmetic right)
  - 01011 shl
  - 01111 div: low = A/B, high = A%B
  - 10000 mul: signed 64-bit product
  - 10001 neg (−B)
  - 10010 not (~B)
  - Shift/rotate amount is B[4:0].
  - Add/sub/logic/shift results: high half = 0.
  - Wraparound on overflow; no flags.
  - Any other opcode yields 0.
  - Div with B=0 yields 0 in both halves.
- Z: ZHighIn loads result[63:32], ZLowIn loads result[31:0]. Both may load in the same cycle.
- Operation latency: one cycle per transfer. Typical sequence:
  - T3: Rxout + Yin
  - T4: Ryout + opcode + ZLowIn
  - T5: Zlowout + Rzin
- IR contents are visible only through the sign-extended constant (Cin). Opcode is an external input, not decoded from IR.

Optional Feature:
- Macro MULDIV_EN.
- Defined: mul (10000) and div (01111) are implemented as above.
- Undefined: both opcodes return 0 and no multiplier/divider logic is built. All other ops are unchanged.

Test Plan:
- Register load: Mdatain=0x12, Read+MDRin for one edge, then MDRout+R4in → R4=0x00000012.
- Shift right: R3=0x7F, R7=0x01. R3out+Yin; then R7out, opcode=01001, ZLowIn; then Zlowout+R4in → R4=0x0000003F.
- Fetch path: Mdatain=0x4A1B8000, Read+MDRin, then MDRout+IRin → IR=0x4A1B8000; Cin drives 0x00038000 on the bus.
- PC: MDRout=0x7 with PCin → PC=7; next edge IncPC alone → PC=8. PCin and IncPC together → PC takes the bus value.
- Mul (MULDIV_EN): Y=0xFFFFFFFE (−2), bus=3, opcode 10000, ZHighIn+ZLowIn → Z={0xFFFFFFFF, 0xFFFFFFFA}. Macro undefined → Z=0.
- Async reset mid-sequence: assert clear between edges → all registers read 0 immediately. Bus priority check: MDRout+PCout together → bus carries MDR.

Source files
------------

// File: rtl/data_path.sv
// data_path: 32-bit single-bus CPU datapath.
// Register file R0-R15, PC, IR, MAR, MDR, Y, HI, LO and a 64-bit Z, all fed
// from one shared bus selected by a fixed-priority encoder. The ALU reads A
// from Y and B from the bus; its 64-bit result is captured into Z halves.
// Every strobe comes from an external sequencer; there is no FSM in here.
//
// Build option: define MULDIV_EN to build the signed multiplier and the
// divider (opcodes 10000 / 01111). Without it those opcodes yield 0.
//
// The register contents and the bus are also brought out as read-only ports
// so the surrounding system (memory address, debug) can observe them.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    clear,
  // bus-drive strobes
  input  logic                    PCout,
  input  logic                    Zhighout,
  input  logic                    Zlowout,
  input  logic                    MDRout,
  input  logic                    R0out,
  input  logic                    R2out,
  input  logic                    R3out,
  input  logic                    R4out,
  input  logic                    R5out,
  input  logic                    R6out,
  input  logic                    R7out,
  input  logic                    Cin,
  // load enables
  input  logic                    MARin,
  input  logic                    PCin,
  input  logic                    MDRin,
  input  logic                    IRin,
  input  logic                    Yin,
  input  logic                    IncPC,
  input  logic                    Read,
  input  logic [4:0]              opcode,
  input  logic                    R0in,
  input  logic                    R1in,
  input  logic                    R2in,
  input  logic                    R3in,
  input  logic                    R4in,
  input  logic                    R5in,
  input  logic                    R6in,
  input  logic                    R7in,
  input  logic                    R8in,
  input  logic                    R9in,
  input  logic                    R10in,
  input  logic                    R11in,
  input  logic                    R12in,
  input  logic                    R13in,
  input  logic                    R14in,
  input  logic                    R15in,
  input  logic                    HIin,
  input  logic                    LOin,
  input  logic                    ZHighIn,
  input  logic                    ZLowIn,
  input  logic [WIDTH-1:0]        Mdatain,
  // observation
  output logic [WIDTH-1:0]        bus,
  output logic [WIDTH-1:0]        pc,
  output logic [WIDTH-1:0]        ir,
  output logic [WIDTH-1:0]        mar,
  output logic [WIDTH-1:0]        mdr,
  output logic [WIDTH-1:0]        y,
  output logic [WIDTH-1:0]        hi,
  output logic [WIDTH-1:0]        lo,
  output logic [2*WIDTH-1:0]      z,
  output logic [15:0][WIDTH-1:0]  regs
);

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  logic [15:0]          reg_in;
  logic [WIDTH-1:0]     c_sign_ext;
  logic [2*WIDTH-1:0]   alu_result;
  logic [4:0]           shamt;
  logic [2*WIDTH-1:0]   ror_wide;
  logic [2*WIDTH-1:0]   rol_wide;
  logic [WIDTH-1:0]     shra_val;
  logic [2*WIDTH-1:0]   mul_prod;
  logic [WIDTH-1:0]     div_quot;
  logic [WIDTH-1:0]     div_rem;

  assign reg_in = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};

  // The immediate field of an instruction is IR[18:0], sign-extended.
  assign c_sign_ext = {{(WIDTH-19){ir[18]}}, ir[18:0]};

  // Fixed-priority bus encoder; simultaneous strobes are legal and the
  // highest-priority one simply wins. Idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (MDRout)        bus = mdr;
    else if (PCout)    bus = pc;
    else if (Zhighout) bus = z[2*WIDTH-1:WIDTH];
    else if (Zlowout)  bus = z[WIDTH-1:0];
    else if (Cin)      bus = c_sign_ext;
    else if (R0out)    bus = regs[0];
    else if (R2out)    bus = regs[2];
    else if (R3out)    bus = regs[3];
    else if (R4out)    bus = regs[4];
    else if (R5out)    bus = regs[5];
    else if (R6out)    bus = regs[6];
    else if (R7out)    bus = regs[7];
  end

  // Shifter operands: rotates take the matching half of a doubled word, so a
  // zero shift amount falls out naturally without a special case.
  assign shamt    = bus[4:0];
  assign ror_wide = {y, y} >> shamt;
  assign rol_wide = {y, y} << shamt;
  assign shra_val = $signed(y) >>> shamt;

`ifdef MULDIV_EN
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;

  // Operands are sign-extended explicitly so the full 64-bit product is signed.
  assign mul_a    = {{WIDTH{y[WIDTH-1]}}, y};
  assign mul_b    = {{WIDTH{bus[WIDTH-1]}}, bus};
  assign mul_prod = $signed(mul_a) * $signed(mul_b);

  // Division by zero is defined to return zero in both halves.
  always_comb begin
    div_quot = '0;
    div_rem  = '0;
    if (bus != '0) begin
      div_quot = $signed(y) / $signed(bus);
      div_rem  = $signed(y) % $signed(bus);
    end
  end
`else
  assign mul_prod = '0;
  assign div_quot = '0;
  assign div_rem  = '0;
`endif

  // ALU: A is always Y, B is always the bus. Single-word results leave the
  // upper half zero; unknown opcodes produce zero.
  always_comb begin
    alu_result = '0;
    unique case (opcode)
      OP_ADD:  alu_result[WIDTH-1:0] = y + bus;
      OP_SUB:  alu_result[WIDTH-1:0] = y - bus;
      OP_AND:  alu_result[WIDTH-1:0] = y & bus;
      OP_OR:   alu_result[WIDTH-1:0] = y | bus;
      OP_ROR:  alu_result[WIDTH-1:0] = ror_wide[WIDTH-1:0];
      OP_ROL:  alu_result[WIDTH-1:0] = rol_wide[2*WIDTH-1:WIDTH];
      OP_SHR:  alu_result[WIDTH-1:0] = y >> shamt;
      OP_SHRA: alu_result[WIDTH-1:0] = shra_val;
      OP_SHL:  alu_result[WIDTH-1:0] = y << shamt;
      OP_DIV:  alu_result = {div_rem, div_quot};
      OP_MUL:  alu_result = mul_prod;
      OP_NEG:  alu_result[WIDTH-1:0] = '0 - bus;
      OP_NOT:  alu_result[WIDTH-1:0] = ~bus;
      default: alu_result = '0;
    endcase
  end

  // PC: a bus load overrides the increment when both are requested.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)      pc <= '0;
    else if (PCin)  pc <= bus;
    else if (IncPC) pc <= pc + 1'b1;
  end

  // MDR: memory read data or bus, selected by Read.
  always_ff @(posedge clock or posedge clear) begin
    if (clear)      mdr <= '0;
    else if (MDRin) mdr <= Read ? Mdatain : bus;
  end

  // Special-purpose registers loaded straight from the bus.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      mar <= '0;
      ir  <= '0;
      y   <= '0;
      hi  <= '0;
      lo  <= '0;
    end else begin
      if (MARin) mar <= bus;
      if (IRin)  ir  <= bus;
      if (Yin)   y   <= bus;
      if (HIin)  hi  <= bus;
      if (LOin)  lo  <= bus;
    end
  end

  // Z halves load independently from the ALU result; both may load together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      z <= '0;
    end else begin
      if (ZHighIn) z[2*WIDTH-1:WIDTH] <= alu_result[2*WIDTH-1:WIDTH];
      if (ZLowIn)  z[WIDTH-1:0]       <= alu_result[WIDTH-1:0];
    end
  end

  // General register file; R0 is an ordinary register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (reg_in[i]) regs[i] <= bus;
      end
    end
  end

endmodule

// File: tb/tb_data_path.sv
// tb_data_path: scoreboard bench for data_path. Expected values are queued
// as stimulus is applied and popped when the corresponding DUT value is
// sampled (#1 after the active edge, or mid-cycle for combinational bus).
module tb_data_path;

  localparam int W = 32;

  logic clock = 1'b0;
  logic clear;
  logic PCout, Zhighout, Zlowout, MDRout, Cin;
  logic MARin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic HIin, LOin, ZHighIn, ZLowIn;
  logic [7:0]   rout;
  logic [15:0]  rin;
  logic [4:0]   opcode;
  logic [W-1:0] Mdatain;

  logic [W-1:0]          bus, pc, ir, mar, mdr, y, hi, lo;
  logic [2*W-1:0]        z;
  logic [15:0][W-1:0]    regs;

  data_path #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R0out(rout[0]), .R2out(rout[2]), .R3out(rout[3]), .R4out(rout[4]),
    .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]), .Cin(Cin),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .IncPC(IncPC), .Read(Read), .opcode(opcode),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn),
    .Mdatain(Mdatain),
    .bus(bus), .pc(pc), .ir(ir), .mar(mar), .mdr(mdr), .y(y), .hi(hi),
    .lo(lo), .z(z), .regs(regs)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      e.tag = "sb_underflow";
      e.val = ~obs;
    end else begin
      e = sb.pop_front();
    end
    check_val(e.tag, obs, e.val);
  endtask

  task automatic idle();
    {PCout, Zhighout, Zlowout, MDRout, Cin} = '0;
    {MARin, PCin, MDRin, IRin, Yin, IncPC, Read} = '0;
    {HIin, LOin, ZHighIn, ZLowIn} = '0;
    rout   = '0;
    rin    = '0;
    opcode = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  task automatic load_mdr(input logic [W-1:0] v);
    Mdatain = v;
    Read    = 1'b1;
    MDRin   = 1'b1;
    tick();
  endtask

  task automatic load_reg(input int idx, input logic [W-1:0] v);
    load_mdr(v);
    MDRout   = 1'b1;
    rin[idx] = 1'b1;
    tick();
  endtask

  // Y <- R2, then Z <- ALU(Y, R3) with both halves loaded.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] op);
    load_reg(2, a);
    load_reg(3, b);
    rout[2] = 1'b1;
    Yin     = 1'b1;
    tick();
    rout[3] = 1'b1;
    opcode  = op;
    ZHighIn = 1'b1;
    ZLowIn  = 1'b1;
    tick();
  endtask

  // Reference ALU for the single-word operations, bit-serial shifts.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int          s;
    logic [31:0] t;
    s = int'(b[4:0]);
    t = a;
    case (op)
      5'd3:  t = a + b;
      5'd4:  t = a - b;
      5'd5:  t = a & b;
      5'd6:  t = a | b;
      5'd7:  for (int i = 0; i < s; i++) t = {t[0], t[31:1]};
      5'd8:  for (int i = 0; i < s; i++) t = {t[30:0], t[31]};
      5'd9:  for (int i = 0; i < s; i++) t = {1'b0, t[31:1]};
      5'd10: for (int i = 0; i < s; i++) t = {t[31], t[31:1]};
      5'd11: for (int i = 0; i < s; i++) t = {t[30:0], 1'b0};
      5'd17: t = 32'd0 - b;
      5'd18: t = ~b;
      default: t = 32'd0;
    endcase
    return {32'd0, t};
  endfunction

  logic [4:0]  ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                            5'd10, 5'd11, 5'd17, 5'd18, 5'd0, 5'd20};
  logic [31:0] ra, rb;

  initial begin
    idle();
    Mdatain = '0;
    clear   = 1'b1;
    #3;
    sb_push("rst_pc", 64'd0);         sb_check(64'(pc));
    sb_push("rst_z", 64'd0);          sb_check(z);
    sb_push("rst_regs_any", 64'd0);   sb_check(64'(|regs));
    sb_push("rst_bus_idle", 64'd0);   sb_check(64'(bus));
    @(negedge clock);
    clear = 1'b0;

    // register load through MDR
    load_mdr(32'h12);
    MDRout = 1'b1; rin[4] = 1'b1;
    tick();
    sb_push("r4_load", 64'h12);       sb_check(64'(regs[4]));

    // shift right example sequence
    load_reg(3, 32'h7F);
    load_reg(7, 32'h01);
    rout[3] = 1'b1; Yin = 1'b1;
    tick();
    rout[7] = 1'b1; opcode = 5'b01001; ZLowIn = 1'b1;
    tick();
    Zlowout = 1'b1; rin[4] = 1'b1;
    tick();
    sb_push("shr_r4", 64'h3F);        sb_check(64'(regs[4]));

    // fetch path and sign-extended constant
    load_mdr(32'h4A1B8000);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    sb_push("ir_load", 64'h4A1B8000); sb_check(64'(ir));
    Cin = 1'b1; #1;
    sb_push("cin_pos", 64'h00038000); sb_check(64'(bus));
    idle();
    load_mdr(32'h0007_FFFF);
    MDRout = 1'b1; IRin = 1'b1;
    tick();
    Cin = 1'b1; #1;
    sb_push("cin_neg", 64'hFFFFFFFF); sb_check(64'(bus));
    idle();

    // PC load, increment, and load-over-increment priority
    load_mdr(32'h7);
    MDRout = 1'b1; PCin = 1'b1;
    tick();
    sb_push("pc_load", 64'd7);        sb_check(64'(pc));
    IncPC = 1'b1;
    tick();
    sb_push("pc_inc", 64'd8);         sb_check(64'(pc));
    load_mdr(32'h100);
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1;
    tick();
    sb_push("pc_prio", 64'h100);      sb_check(64'(pc));

    // MAR from bus
    load_mdr(32'hCAFE_0010);
    MDRout = 1'b1; MARin = 1'b1;
    tick();
    sb_push("mar_load", 64'hCAFE0010); sb_check(64'(mar));

    // bus priority: MDR over PC, PC over Zlow, then idle
    MDRout = 1'b1; PCout = 1'b1; #1;
    sb_push("prio_mdr_pc", 64'hCAFE0010); sb_check(64'(bus));
    MDRout = 1'b0; Zlowout = 1'b1; #1;
    sb_push("prio_pc_zlo", 64'h100);  sb_check(64'(bus));
    idle(); #1;
    sb_push("bus_idle", 64'd0);       sb_check(64'(bus));

    // multiply / divide
    run_op(32'hFFFFFFFE, 32'd3, 5'b10000);
`ifdef MULDIV_EN
    sb_push("mul_z", 64'hFFFFFFFF_FFFFFFFA);
`else
    sb_push("mul_z", 64'd0);
`endif
    sb_check(z);
    Zhighout = 1'b1; HIin = 1'b1;
    tick();
`ifdef MULDIV_EN
    sb_push("hi_load", 64'hFFFFFFFF);
`else
    sb_push("hi_load", 64'd0);
`endif
    sb_check(64'(hi));
    run_op(32'd17, 32'd5, 5'b01111);
`ifdef MULDIV_EN
    sb_push("div_z", {32'd2, 32'd3});
`else
    sb_push("div_z", 64'd0);
`endif
    sb_check(z);
    run_op(32'd17, 32'd0, 5'b01111);
    sb_push("div_by_zero", 64'd0);    sb_check(z);

    // every other opcode against the reference model, plus edge operands
    foreach (ops[k]) begin
      ra = $urandom();
      rb = $urandom();
      run_op(ra, rb, ops[k]);
      sb_push($sformatf("alu_op%0d", ops[k]), alu_model(ops[k], ra, rb));
      sb_check(z);
    end
    run_op(32'h8000_0001, 32'd31, 5'b00111);
    sb_push("ror_31", alu_model(5'd7, 32'h8000_0001, 32'd31)); sb_check(z);
    run_op(32'h8000_0000, 32'd0, 5'b01010);
    sb_push("shra_0", 64'h8000_0000); sb_check(z);
    run_op(32'hFFFF_FFFF, 32'd1, 5'b00011);
    sb_push("add_wrap", 64'd0);       sb_check(z);

    // asynchronous clear between edges
    load_reg(5, 32'h5555_AAAA);
    #2;
    clear = 1'b1;
    #1;
    sb_push("aclr_regs_any", 64'd0);  sb_check(64'(|regs));
    sb_push("aclr_pc", 64'd0);        sb_check(64'(pc));
    sb_push("aclr_mdr", 64'd0);       sb_check(64'(mdr));
    sb_push("aclr_z", 64'd0);         sb_check(z);
    @(negedge clock);
    clear = 1'b0;

    if (sb.size() != 0) check_val("sb_leftover", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
